id_ex_stage: RTL and testbench

- Decode-to-execute pipeline register of the MIPS datapath, directly downstream of the main control decoder.
- Registers the decoder's control bundle plus the register-file and immediate operands into the EX stage.
- Detects load-use hazards and inserts one bubble, asserting a stall to the PC and IF/ID register.
- Honours a branch flush and keeps a saturating stall counter for performance analysis.

---
 rtl/dptr_pkg.sv | 27 ++
 rtl/load_use_detect.sv | 25 ++
 rtl/id_ex_stage.sv | 142 ++++++++++++++
 tb/tb_id_ex_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dptr_pkg.sv
// Shared datapath types for the MIPS pipeline:
// decoder control bundle and ALU op encodings.
package dptr_pkg;

  localparam logic [3:0] ALUOP_LWSW  = 4'b0000;
  localparam logic [3:0] ALUOP_BEQ   = 4'b0001;
  localparam logic [3:0] ALUOP_RTYPE = 4'b0010;
  localparam logic [3:0] ALUOP_ADDI  = 4'b0011;
  localparam logic [3:0] ALUOP_ANDI  = 4'b0100;
  localparam logic [3:0] ALUOP_ORI   = 4'b0101;
  localparam logic [3:0] ALUOP_SLTI  = 4'b0110;
  localparam logic [3:0] ALUOP_XORI  = 4'b0111;

  typedef struct packed {
    logic       regDst;
    logic       branch;
    logic       memToRead;
    logic       memToReg;
    logic       memToWrite;
    logic       aluSrc;
    logic       regWrite;
    logic [3:0] aluOp;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard check between the load in EX
// and the instruction waiting in ID.
module load_use_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  exValid,
  input  logic                  exMemToRead,
  input  logic [REG_ADDR_W-1:0] exRt,
  input  logic [REG_ADDR_W-1:0] idRs,
  input  logic [REG_ADDR_W-1:0] idRt,
  input  logic                  idUseRt,
  output logic                  hz
);

  logic exLoad;
  logic rsHit;
  logic rtHit;

  // $0 is hardwired, so a load into it never conflicts
  assign exLoad = exValid & exMemToRead & (exRt != '0);
  assign rsHit  = (exRt == idRs);
  assign rtHit  = idUseRt & (exRt == idRt);
  assign hz     = exLoad & (rsHit | rtHit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble,
// branch flush and saturating stall counter.
module id_ex_stage
  import dptr_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  regDst_i,
  input  logic                  branch_i,
  input  logic                  memToRead_i,
  input  logic                  memToReg_i,
  input  logic                  memToWrite_i,
  input  logic                  aluSrc_i,
  input  logic                  regWrite_i,
  input  logic [3:0]            aluOp_i,
  input  logic                  valid_i,
  input  logic [DATA_W-1:0]     pcPlus4_i,
  input  logic [DATA_W-1:0]     readData1_i,
  input  logic [DATA_W-1:0]     readData2_i,
  input  logic [DATA_W-1:0]     signImm_i,
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [REG_ADDR_W-1:0] rt_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  flush_i,
  output logic                  exRegDst_o,
  output logic                  exBranch_o,
  output logic                  exMemToRead_o,
  output logic                  exMemToReg_o,
  output logic                  exMemToWrite_o,
  output logic                  exAluSrc_o,
  output logic                  exRegWrite_o,
  output logic [3:0]            exAluOp_o,
  output logic                  exValid_o,
  output logic [DATA_W-1:0]     exPcPlus4_o,
  output logic [DATA_W-1:0]     exReadData1_o,
  output logic [DATA_W-1:0]     exReadData2_o,
  output logic [DATA_W-1:0]     exSignImm_o,
  output logic [REG_ADDR_W-1:0] exRs_o,
  output logic [REG_ADDR_W-1:0] exRt_o,
  output logic [REG_ADDR_W-1:0] exRd_o,
  output logic                  stall_o,
  output logic [CNT_W-1:0]      stallCount_o
);

  ctrl_t                 idCtrl;
  ctrl_t                 exCtrl;
  logic                  exValid;
  logic [DATA_W-1:0]     exPc;
  logic [DATA_W-1:0]     exRd1;
  logic [DATA_W-1:0]     exRd2;
  logic [DATA_W-1:0]     exImm;
  logic [REG_ADDR_W-1:0] exRs;
  logic [REG_ADDR_W-1:0] exRt;
  logic [REG_ADDR_W-1:0] exRd;
  logic [CNT_W-1:0]      stallCnt;
  logic                  useRt;
  logic                  hz;

  assign idCtrl = '{
    regDst:     regDst_i,
    branch:     branch_i,
    memToRead:  memToRead_i,
    memToReg:   memToReg_i,
    memToWrite: memToWrite_i,
    aluSrc:     aluSrc_i,
    regWrite:   regWrite_i,
    aluOp:      aluOp_i
  };

  // R-type, sw and beq read rt as a source
  assign useRt = valid_i
    & (regDst_i | memToWrite_i | branch_i);

  load_use_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) uHz (
    .exValid    (exValid),
    .exMemToRead(exCtrl.memToRead),
    .exRt       (exRt),
    .idRs       (rs_i),
    .idRt       (rt_i),
    .idUseRt    (useRt),
    .hz         (hz)
  );

  assign stall_o = hz & ~flush_i & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i || hz) begin
      exCtrl  <= CTRL_BUBBLE;
      exValid <= 1'b0;
      exPc    <= '0;
      exRd1   <= '0;
      exRd2   <= '0;
      exImm   <= '0;
      exRs    <= '0;
      exRt    <= '0;
      exRd    <= '0;
    end else begin
      exCtrl  <= idCtrl;
      exValid <= valid_i;
      exPc    <= pcPlus4_i;
      exRd1   <= readData1_i;
      exRd2   <= readData2_i;
      exImm   <= signImm_i;
      exRs    <= rs_i;
      exRt    <= rt_i;
      exRd    <= rd_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stallCnt <= '0;
    end else if (stall_o && stallCnt != '1) begin
      stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  assign exRegDst_o     = exCtrl.regDst;
  assign exBranch_o     = exCtrl.branch;
  assign exMemToRead_o  = exCtrl.memToRead;
  assign exMemToReg_o   = exCtrl.memToReg;
  assign exMemToWrite_o = exCtrl.memToWrite;
  assign exAluSrc_o     = exCtrl.aluSrc;
  assign exRegWrite_o   = exCtrl.regWrite;
  assign exAluOp_o      = exCtrl.aluOp;
  assign exValid_o      = exValid;
  assign exPcPlus4_o    = exPc;
  assign exReadData1_o  = exRd1;
  assign exReadData2_o  = exRd2;
  assign exSignImm_o    = exImm;
  assign exRs_o         = exRs;
  assign exRt_o         = exRt;
  assign exRd_o         = exRd;
  assign stallCount_o   = stallCnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed checks for id_ex_stage: reset, pass-through,
// load-use stall, flush priority and counter saturation.
module tb_id_ex_stage;
  import dptr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        regDst, branch, memToRead, memToReg;
  logic        memToWrite, aluSrc, regWrite;
  logic [3:0]  aluOp;
  logic        valid;
  logic [31:0] pcPlus4, rd1, rd2, signImm;
  logic [4:0]  rs, rt, rd;
  logic        flush;

  logic        xRegDst, xBranch, xMemRd, xMemToReg;
  logic        xMemWr, xAluSrc, xRegWrite;
  logic [3:0]  xAluOp;
  logic        xValid;
  logic [31:0] xPc, xRd1, xRd2, xImm;
  logic [4:0]  xRs, xRt, xRd;
  logic        stall;
  logic [15:0] cnt;

  logic        bRegDst, bBranch, bMemRd, bMemToReg;
  logic        bMemWr, bAluSrc, bRegWrite;
  logic [3:0]  bAluOp;
  logic        bValid;
  logic [31:0] bPc, bRd1, bRd2, bImm;
  logic [4:0]  bRs, bRt, bRd;
  logic        bStall;
  logic [1:0]  bCnt;

  int nRun  = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  id_ex_stage uDut (
    .clk_i(clk), .rst_i(rst),
    .regDst_i(regDst), .branch_i(branch),
    .memToRead_i(memToRead), .memToReg_i(memToReg),
    .memToWrite_i(memToWrite), .aluSrc_i(aluSrc),
    .regWrite_i(regWrite), .aluOp_i(aluOp),
    .valid_i(valid), .pcPlus4_i(pcPlus4),
    .readData1_i(rd1), .readData2_i(rd2),
    .signImm_i(signImm),
    .rs_i(rs), .rt_i(rt), .rd_i(rd),
    .flush_i(flush),
    .exRegDst_o(xRegDst), .exBranch_o(xBranch),
    .exMemToRead_o(xMemRd), .exMemToReg_o(xMemToReg),
    .exMemToWrite_o(xMemWr), .exAluSrc_o(xAluSrc),
    .exRegWrite_o(xRegWrite), .exAluOp_o(xAluOp),
    .exValid_o(xValid), .exPcPlus4_o(xPc),
    .exReadData1_o(xRd1), .exReadData2_o(xRd2),
    .exSignImm_o(xImm),
    .exRs_o(xRs), .exRt_o(xRt), .exRd_o(xRd),
    .stall_o(stall), .stallCount_o(cnt)
  );

  id_ex_stage #(.CNT_W(2)) uSat (
    .clk_i(clk), .rst_i(rst),
    .regDst_i(regDst), .branch_i(branch),
    .memToRead_i(memToRead), .memToReg_i(memToReg),
    .memToWrite_i(memToWrite), .aluSrc_i(aluSrc),
    .regWrite_i(regWrite), .aluOp_i(aluOp),
    .valid_i(valid), .pcPlus4_i(pcPlus4),
    .readData1_i(rd1), .readData2_i(rd2),
    .signImm_i(signImm),
    .rs_i(rs), .rt_i(rt), .rd_i(rd),
    .flush_i(flush),
    .exRegDst_o(bRegDst), .exBranch_o(bBranch),
    .exMemToRead_o(bMemRd), .exMemToReg_o(bMemToReg),
    .exMemToWrite_o(bMemWr), .exAluSrc_o(bAluSrc),
    .exRegWrite_o(bRegWrite), .exAluOp_o(bAluOp),
    .exValid_o(bValid), .exPcPlus4_o(bPc),
    .exReadData1_o(bRd1), .exReadData2_o(bRd2),
    .exSignImm_o(bImm),
    .exRs_o(bRs), .exRt_o(bRt), .exRd_o(bRd),
    .stall_o(bStall), .stallCount_o(bCnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nRun++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clrCtrl();
    regDst = 0; branch = 0; memToRead = 0;
    memToReg = 0; memToWrite = 0; aluSrc = 0;
    regWrite = 0; aluOp = ALUOP_LWSW;
  endtask

  task automatic setIdle();
    clrCtrl();
    valid = 0; pcPlus4 = 0; rd1 = 0; rd2 = 0;
    signImm = 0; rs = 0; rt = 0; rd = 0; flush = 0;
  endtask

  task automatic setLw(input logic [4:0] s,
                       input logic [4:0] t);
    clrCtrl();
    memToRead = 1; memToReg = 1; aluSrc = 1;
    regWrite = 1; aluOp = ALUOP_LWSW;
    valid = 1; rs = s; rt = t; rd = 0;
    signImm = 32'h4; pcPlus4 = 32'h200;
  endtask

  task automatic setAdd(input logic [4:0] s,
                        input logic [4:0] t,
                        input logic [4:0] d);
    clrCtrl();
    regDst = 1; regWrite = 1; aluOp = ALUOP_RTYPE;
    valid = 1; rs = s; rt = t; rd = d;
    signImm = 0; pcPlus4 = 32'h204;
  endtask

  task automatic setSw(input logic [4:0] s,
                       input logic [4:0] t);
    clrCtrl();
    memToWrite = 1; aluSrc = 1; aluOp = ALUOP_LWSW;
    valid = 1; rs = s; rt = t; rd = 0;
  endtask

  task automatic setAddi(input logic [4:0] s,
                         input logic [4:0] t,
                         input logic [31:0] imm);
    clrCtrl();
    aluSrc = 1; regWrite = 1; aluOp = ALUOP_ADDI;
    valid = 1; rs = s; rt = t; rd = 0;
    signImm = imm; pcPlus4 = 32'h100;
  endtask

  initial begin
    setIdle();
    rst = 1;
    // reset with random stimulus on every input
    {regDst, branch, memToRead, memToReg} = 4'($urandom);
    {memToWrite, aluSrc, regWrite} = 3'($urandom);
    aluOp = 4'($urandom);
    valid = 1; flush = 0;
    pcPlus4 = $urandom; rd1 = $urandom;
    rd2 = $urandom; signImm = $urandom;
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    #1;
    chk("rstStall0", 32'(stall), 0);
    step();
    chk("rstStall1", 32'(stall), 0);
    step();
    chk("rstValid", 32'(xValid), 0);
    chk("rstAluOp", 32'(xAluOp), 0);
    chk("rstCtrl", 32'({xRegDst, xBranch, xMemRd,
        xMemToReg, xMemWr, xAluSrc, xRegWrite}), 0);
    chk("rstData", xPc | xRd1 | xRd2 | xImm, 0);
    chk("rstRegs", 32'({xRs, xRt, xRd}), 0);
    chk("rstCnt", 32'(cnt), 0);
    chk("rstStall2", 32'(stall), 0);

    rst = 0;
    setAddi(5'd1, 5'd5, 32'h10);
    #1;
    chk("addiStall", 32'(stall), 0);
    step();
    chk("addiAluOp", 32'(xAluOp), 32'(ALUOP_ADDI));
    chk("addiRt", 32'(xRt), 5);
    chk("addiImm", xImm, 32'h10);
    chk("addiValid", 32'(xValid), 1);
    chk("addiSrcWr", 32'({xAluSrc, xRegWrite}), 3);
    chk("addiPc", xPc, 32'h100);

    // lw $8 ; add $3,$8,$9
    setLw(5'd1, 5'd8);
    #1;
    chk("lwNoStall", 32'(stall), 0);
    step();
    setAdd(5'd8, 5'd9, 5'd3);
    #1;
    chk("luStall", 32'(stall), 1);
    step();
    chk("luBubValid", 32'(xValid), 0);
    chk("luBubWr", 32'(xRegWrite), 0);
    chk("luBubRs", 32'(xRs), 0);
    chk("luCnt", 32'(cnt), 1);
    chk("luStallOnce", 32'(stall), 0);
    step();
    chk("luAddValid", 32'(xValid), 1);
    chk("luAddRd", 32'(xRd), 3);
    chk("luAddRs", 32'(xRs), 8);
    chk("luAddDst", 32'(xRegDst), 1);
    chk("luCntHold", 32'(cnt), 1);

    // load into $0 never stalls
    setLw(5'd1, 5'd0);
    step();
    setAdd(5'd0, 5'd9, 5'd4);
    #1;
    chk("lw0Stall", 32'(stall), 0);
    step();
    chk("lw0Valid", 32'(xValid), 1);
    chk("lw0Rd", 32'(xRd), 4);

    // addi does not read rt
    setLw(5'd1, 5'd8);
    step();
    setAddi(5'd4, 5'd8, 32'h7);
    #1;
    chk("addiRtStall", 32'(stall), 0);
    step();
    chk("addiRtOp", 32'(xAluOp), 32'(ALUOP_ADDI));
    chk("addiRtValid", 32'(xValid), 1);

    // sw reads rt as store data
    setLw(5'd1, 5'd8);
    step();
    setSw(5'd2, 5'd8);
    #1;
    chk("swStall", 32'(stall), 1);
    step();
    chk("swBub", 32'(xValid), 0);
    chk("swCnt", 32'(cnt), 2);
    step();
    chk("swCap", 32'(xMemWr), 1);

    // flush wins over hazard, no count
    setLw(5'd1, 5'd8);
    step();
    setAdd(5'd8, 5'd9, 5'd3);
    flush = 1;
    #1;
    chk("flStall", 32'(stall), 0);
    step();
    chk("flValid", 32'(xValid), 0);
    chk("flWr", 32'(xRegWrite), 0);
    chk("flRd", 32'(xRd), 0);
    chk("flCnt", 32'(cnt), 2);
    flush = 0;

    // counter saturation on the 2-bit instance
    setIdle();
    rst = 1;
    step();
    rst = 0;
    chk("satRst", 32'(bCnt), 0);
    for (int i = 0; i < 4; i++) begin
      setLw(5'd1, 5'd8);
      step();
      setAdd(5'd8, 5'd9, 5'd3);
      #1;
      chk($sformatf("satStall%0d", i), 32'(bStall), 1);
      step();
      chk($sformatf("satCnt%0d", i), 32'(bCnt),
          (i < 3) ? 32'(i + 1) : 32'd3);
      chk($sformatf("wideCnt%0d", i), 32'(cnt),
          32'(i + 1));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule
